argon_bus_sequencer: RTL and testbench

ARGON_BUS_SEQUENCER -- requirements
Module: argon_bus_sequencer

---
 rtl/constants_pkg.sv | 11 +
 rtl/seq_pkg.sv | 33 +++
 rtl/argon_seq_fifo.sv | 66 ++++++
 rtl/argon_bus_sequencer.sv | 141 ++++++++++++++
 tb/tb_argon_bus_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/constants_pkg.sv
// Project-wide constants shared by the bus sequencer and its neighbours.
package constants_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Unit id that no bus agent answers to.
    localparam logic [3:0] ID_NONE = 4'hF;

endpackage

// File: rtl/seq_pkg.sv
// Types and helpers for argon_bus_sequencer: FSM states and the packed transfer instruction.
package seq_pkg;

    import constants_pkg::*;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCommit,
        StError
    } seq_state_t;

    typedef struct packed {
        logic [3:0] src_id;
        logic [3:0] src_cmd;
        logic [3:0] dst_id;
        logic [3:0] dst_cmd;
    } seq_instr_t;

    localparam seq_instr_t InstrNone = '{
        src_id:  ID_NONE,
        src_cmd: 4'h0,
        dst_id:  ID_NONE,
        dst_cmd: 4'h0
    };

    // A transfer onto itself or to/from the unassigned id cannot be executed.
    function automatic logic instr_invalid(input seq_instr_t instr);
        return (instr.src_id == instr.dst_id) || (instr.src_id == ID_NONE) ||
               (instr.dst_id == ID_NONE);
    endfunction

endpackage

// File: rtl/argon_seq_fifo.sv
// Instruction queue for argon_bus_sequencer: power-of-two ring buffer with flush.
module argon_seq_fifo
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  seq_instr_t                   data_i,
    input  logic                         pop_i,
    output seq_instr_t                   data_o,
    input  logic                         flush_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH + 1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    seq_instr_t      mem_q [DEPTH];
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/argon_bus_sequencer.sv
// Queues bus transfer instructions and drives the master bus mux one transfer at a time.
// Optional DRIVE-state watchdog enabled by defining ARGON_SEQ_TIMEOUT_EN.
module argon_bus_sequencer
    import constants_pkg::*;
    import seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  word_t      i_instr,
    input  logic       i_instr_valid,
    output logic       o_instr_ready,
    input  logic       i_bus_valid,
    output logic [3:0] o_write_id,
    output logic [3:0] o_write_command,
    output logic [3:0] o_read_id,
    output logic [3:0] o_read_command,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    input  logic       i_error_clear
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
    begin : g_bad_params
        $error("argon_bus_sequencer: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES > 0");
    end

    seq_state_t state_q;
    seq_instr_t cur_q;
    logic       busy_q, done_q, error_q;

    logic       fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    seq_instr_t fifo_head;
    logic [CntW-1:0]        unused_fifo_count;
    logic [WORD_W-17:0]     unused_instr_hi;

    assign unused_instr_hi = i_instr[WORD_W-1:16];

    assign o_instr_ready = !fifo_full && (state_q != StError);
    assign fifo_push     = i_instr_valid && o_instr_ready;
    // The head is consumed whenever the FSM is ready to start a new transfer.
    assign fifo_pop      = ((state_q == StIdle) || (state_q == StCommit)) && !fifo_empty;
    assign fifo_flush    = (state_q == StError);

    argon_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_Clk),
        .rst_i   (i_Reset),
        .push_i  (fifo_push),
        .data_i  (seq_instr_t'(i_instr[15:0])),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .flush_i (fifo_flush),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

`ifdef ARGON_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q;
`endif

    // cur_q doubles as the registered mux/command output; it holds InstrNone outside a transfer.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= StIdle;
            cur_q   <= InstrNone;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef ARGON_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StCommit: begin
                    if (fifo_pop) begin
                        busy_q <= 1'b1;
                        if (instr_invalid(fifo_head)) begin
                            state_q <= StError;
                            cur_q   <= InstrNone;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= StDrive;
                            cur_q   <= fifo_head;
`ifdef ARGON_SEQ_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end
                    end else begin
                        state_q <= StIdle;
                        cur_q   <= InstrNone;
                        busy_q  <= 1'b0;
                    end
                end
                StDrive: begin
                    if (i_bus_valid) begin
                        state_q <= StCommit;
                        done_q  <= 1'b1;
                    end
`ifdef ARGON_SEQ_TIMEOUT_EN
                    else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= StError;
                        cur_q   <= InstrNone;
                        error_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
`endif
                end
                StError: begin
                    if (i_error_clear) begin
                        state_q <= StIdle;
                        error_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_write_id      = cur_q.src_id;
    assign o_write_command = cur_q.src_cmd;
    assign o_read_id       = cur_q.dst_id;
    assign o_read_command  = cur_q.dst_cmd;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_error         = error_q;

endmodule

// File: tb/tb_argon_bus_sequencer.sv
// Scoreboard bench for argon_bus_sequencer: directed scenarios plus randomized traffic.
module tb_argon_bus_sequencer;

    localparam int unsigned Tmo = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid, instr_ready, bus_valid, error_clear;
    logic [3:0]  wr_id, wr_cmd, rd_id, rd_cmd;
    logic        busy, done, error;

    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q [$];
    logic        err_prev = 1'b0;
    logic [15:0] mon_outs, mon_e;

    always #5 clk = ~clk;

    argon_bus_sequencer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .i_Clk           (clk),
        .i_Reset         (rst),
        .i_instr         (instr),
        .i_instr_valid   (instr_valid),
        .o_instr_ready   (instr_ready),
        .i_bus_valid     (bus_valid),
        .o_write_id      (wr_id),
        .o_write_command (wr_cmd),
        .o_read_id       (rd_id),
        .o_read_command  (rd_cmd),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error),
        .i_error_clear   (error_clear)
    );

    function automatic logic is_bad(input logic [15:0] w);
        return (w[15:12] == w[7:4]) || (w[15:12] == 4'hF) || (w[7:4] == 4'hF);
    endfunction

    function automatic logic [15:0] gen_instr();
        logic [3:0] s, d;
        if ($urandom_range(9) == 0) begin
            s = 4'($urandom_range(15));
            d = ($urandom_range(1) == 0) ? s : 4'hF;
        end else begin
            s = 4'($urandom_range(14));
            d = 4'((32'(s) + 1 + $urandom_range(13)) % 15);
        end
        return {s, 4'($urandom_range(15)), d, 4'($urandom_range(15))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    // Monitor: completed transfers must match accepted instructions in order; a fault drops
    // everything queued so far; idle/error cycles show the unassigned id on the bus.
    always @(negedge clk) begin
        mon_outs = {wr_id, wr_cmd, rd_id, rd_cmd};
        if (rst) begin
            exp_q.delete();
            err_prev = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_good_instr", 32'(is_bad(mon_e)), 32'(0));
                    check("done_instr", 32'(mon_outs), 32'(mon_e));
                end
            end
            if (error && !err_prev) begin
                if (exp_q.size() == 0) begin
                    check("error_without_instr", 32'(error), 32'(0));
                end else begin
`ifndef ARGON_SEQ_TIMEOUT_EN
                    check("error_cause_bad", 32'(is_bad(exp_q[0])), 32'(1));
`endif
                    exp_q.delete();
                end
            end
            if (error || !busy) begin
                check("idle_outputs", 32'(mon_outs), 32'h0000_F0F0);
            end
            err_prev = error;
            if (instr_valid && instr_ready) begin
                exp_q.push_back(instr[15:0]);
            end
        end
    end

    initial begin
        int base;
        int ndone;
        int cyc [8];

        rst         = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        bus_valid   = 1'b0;
        error_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ready", 32'(instr_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        check("rst_outputs", 32'({wr_id, wr_cmd, rd_id, rd_cmd}), 32'h0000_F0F0);

        // Single transfer with the bus already valid; upper word bits are ignored.
        bus_valid = 1'b1;
        push_one(32'hABCD_1234);
        check("a_idle_after_push", 32'(busy), 32'(0));
        tick();
        check("a_drive_outputs", 32'({wr_id, wr_cmd, rd_id, rd_cmd}), 32'h0000_1234);
        check("a_drive_no_done", 32'(done), 32'(0));
        check("a_drive_busy", 32'(busy), 32'(1));
        tick();
        check("a_commit_done", 32'(done), 32'(1));
        check("a_commit_outputs", 32'({wr_id, wr_cmd, rd_id, rd_cmd}), 32'h0000_1234);
        tick();
        check("a_idle_done", 32'(done), 32'(0));
        check("a_idle_busy", 32'(busy), 32'(0));

        // Fill the queue behind a stalled transfer, then release the bus.
        bus_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_one({16'h0, 4'(i + 1), 4'(i), 4'(i + 6), 4'(i + 9)});
        end
        check("b_full_ready", 32'(instr_ready), 32'(0));
        check("b_stalled_busy", 32'(busy), 32'(1));
        push_one(32'h0000_7182);  // refused while full
        base      = done_cnt;
        ndone     = 0;
        bus_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done) begin
                if (ndone < 8) cyc[ndone] = c;
                ndone++;
            end
        end
        check("b_done_count", 32'(ndone), 32'(5));
        for (int k = 1; k < 5 && k < ndone; k++) begin
            check("b_done_spacing", 32'(cyc[k] - cyc[k-1]), 32'(2));
        end
        check("b_monitor_dones", 32'(done_cnt - base), 32'(5));

        // Self-transfer faults; the instruction queued behind it is flushed.
        bus_valid = 1'b0;
        push_one(32'h0000_2122);
        push_one(32'h0000_3141);
        check("c_error", 32'(error), 32'(1));
        check("c_error_busy", 32'(busy), 32'(1));
        check("c_error_ready", 32'(instr_ready), 32'(0));
        check("c_error_outputs", 32'({wr_id, wr_cmd, rd_id, rd_cmd}), 32'h0000_F0F0);
        repeat (2) tick();
        check("c_error_sticky", 32'(error), 32'(1));
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("c_cleared_error", 32'(error), 32'(0));
        check("c_cleared_busy", 32'(busy), 32'(0));
        check("c_cleared_ready", 32'(instr_ready), 32'(1));
        base      = done_cnt;
        bus_valid = 1'b1;
        repeat (6) tick();
        check("c_flushed", 32'(done_cnt - base), 32'(0));

        // Bus never answers.
        bus_valid = 1'b0;
        push_one(32'h0000_3456);
        tick();
`ifdef ARGON_SEQ_TIMEOUT_EN
        repeat (Tmo - 1) tick();
        check("d_before_timeout", 32'(error), 32'(0));
        check("d_before_timeout_out", 32'({wr_id, wr_cmd, rd_id, rd_cmd}), 32'h0000_3456);
        tick();
        check("d_timeout_error", 32'(error), 32'(1));
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("d_timeout_cleared", 32'(error), 32'(0));
`else
        repeat (100) tick();
        check("d_still_busy", 32'(busy), 32'(1));
        check("d_no_error", 32'(error), 32'(0));
        check("d_still_driving", 32'({wr_id, wr_cmd, rd_id, rd_cmd}), 32'h0000_3456);
        bus_valid = 1'b1;
        tick();
        check("d_late_done", 32'(done), 32'(1));
        tick();
        check("d_late_idle", 32'(busy), 32'(0));
`endif

        // Reset in the middle of a transfer with two entries queued.
        bus_valid = 1'b0;
        push_one(32'h0000_1526);
        push_one(32'h0000_2637);
        push_one(32'h0000_3748);
        check("e_busy_before_reset", 32'(busy), 32'(1));
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("e_reset_outputs", 32'({wr_id, wr_cmd, rd_id, rd_cmd}), 32'h0000_F0F0);
        check("e_reset_busy", 32'(busy), 32'(0));
        check("e_reset_done", 32'(done), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("e_ready_after", 32'(instr_ready), 32'(1));
        base      = done_cnt;
        bus_valid = 1'b1;
        repeat (8) tick();
        check("e_no_done", 32'(done_cnt - base), 32'(0));
        check("e_idle", 32'(busy), 32'(0));

        // Randomized traffic against the scoreboard.
        for (int n = 0; n < 400; n++) begin
            instr_valid = ($urandom_range(9) < 6);
            instr       = {16'($urandom()), gen_instr()};
            bus_valid   = ($urandom_range(9) < 7);
            error_clear = ($urandom_range(3) == 0);
            tick();
        end
        instr_valid = 1'b0;
        bus_valid   = 1'b1;
        error_clear = 1'b1;
        repeat (20) tick();
        error_clear = 1'b0;
        tick();
        check("f_drained", 32'(exp_q.size()), 32'(0));
        check("f_idle", 32'(busy), 32'(0));
        check("f_no_error", 32'(error), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
